// File: rtl/trigger_wheel_gen.sv
// trigger_wheel_gen: crank trigger-wheel emulator (TEETH-GAP pattern) with a
// cam output that repeats every two revolutions.
// Optional feature: define TRIGGER_WHEEL_GEN_RAMP_EN to slew the tooth period
// toward the requested value by at most ramp_step per slot. Without it the
// period jumps straight to the requested value and ramp_step is ignored.
module trigger_wheel_gen #(
    parameter int unsigned TEETH      = 60,
    parameter int unsigned GAP        = 2,
    parameter int unsigned PW         = 16,
    parameter int unsigned PERIOD_RST = 8,
    parameter int unsigned CAM_ON     = 4,
    parameter int unsigned CAM_OFF    = 54
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [PW-1:0]              period,
    input  logic                       period_ld,
    input  logic [PW-1:0]              ramp_step,
    output logic                       vr,
    output logic                       cam,
    output logic [$clog2(TEETH)-1:0]   tooth_idx,
    output logic                       tooth_strobe,
    output logic                       rev_strobe
);

    localparam int unsigned IW = $clog2(TEETH);

    localparam logic [IW-1:0] LAST_IDX    = IW'(TEETH - 1);
    localparam logic [IW:0]   TOOTH_LIM   = (IW+1)'(TEETH - GAP);
    localparam logic [IW-1:0] CAM_ON_IDX  = IW'(CAM_ON);
    localparam logic [IW-1:0] CAM_OFF_IDX = IW'(CAM_OFF);
    localparam logic [PW-1:0] PER_MIN     = PW'(2);
    localparam logic [PW-1:0] PER_RST     = PW'(PERIOD_RST);

    // Registered state
    logic [PW-1:0] tick;
    logic [PW-1:0] per;
    logic [PW-1:0] target;
    logic          cam_phase;

    // Next-state values
    logic [PW-1:0] tick_nxt;
    logic [PW-1:0] per_nxt;
    logic [PW-1:0] target_nxt;
    logic          phase_nxt;
    logic [IW-1:0] idx_nxt;
    logic          vr_nxt;
    logic          cam_nxt;
    logic          ts_nxt;
    logic          rs_nxt;

    // Decode helpers
    logic [PW-1:0] ld_val_c;
    logic [PW-1:0] per_next_c;
    logic          slot_end_c;
    logic          vr_rise_c;
    logic          wrap_c;
    logic [IW-1:0] idx_inc_c;

    // Clamp a requested period and select the target the next slot aims for
    always_comb begin
        ld_val_c   = (period < PER_MIN) ? PER_MIN : period;
        target_nxt = period_ld ? ld_val_c : target;
    end

    // Slot timing decode: end of slot, rising point of the tooth, wrap
    always_comb begin
        slot_end_c = (tick == (per - PW'(1)));
        vr_rise_c  = ((tick + PW'(1)) == (per >> 1)) &&
                     ({1'b0, tooth_idx} < TOOTH_LIM);
        wrap_c     = (tooth_idx == LAST_IDX);
        idx_inc_c  = wrap_c ? '0 : (tooth_idx + IW'(1));
    end

`ifdef TRIGGER_WHEEL_GEN_RAMP_EN
    logic [PW-1:0] dist_c;
    logic          up_c;

    // Period for the next slot: step toward target, never past it
    always_comb begin
        up_c   = (target_nxt > per);
        dist_c = up_c ? (target_nxt - per) : (per - target_nxt);
        if ((ramp_step == '0) || (dist_c <= ramp_step)) begin
            per_next_c = target_nxt;
        end else if (up_c) begin
            per_next_c = per + ramp_step;
        end else begin
            per_next_c = per - ramp_step;
        end
    end
`else
    logic unused_ramp_step;
    assign unused_ramp_step = ^ramp_step;

    // Period for the next slot: take the target directly
    always_comb begin
        per_next_c = target_nxt;
    end
`endif

    // Next-state logic: everything holds unless enabled; strobes default low
    always_comb begin
        tick_nxt  = tick;
        idx_nxt   = tooth_idx;
        per_nxt   = per;
        phase_nxt = cam_phase;
        vr_nxt    = vr;
        cam_nxt   = cam;
        ts_nxt    = 1'b0;
        rs_nxt    = 1'b0;
        if (ena) begin
            if (slot_end_c) begin
                tick_nxt = '0;
                idx_nxt  = idx_inc_c;
                per_nxt  = per_next_c;
                vr_nxt   = 1'b0;
                ts_nxt   = 1'b1;
                if (wrap_c) begin
                    rs_nxt    = 1'b1;
                    phase_nxt = ~cam_phase;
                end
                if (idx_inc_c == CAM_OFF_IDX) begin
                    cam_nxt = 1'b0;
                end else if ((idx_inc_c == CAM_ON_IDX) && phase_nxt) begin
                    cam_nxt = 1'b1;
                end
            end else begin
                tick_nxt = tick + PW'(1);
                if (vr_rise_c) begin
                    vr_nxt = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tick         <= '0;
            tooth_idx    <= '0;
            per          <= PER_RST;
            target       <= PER_RST;
            cam_phase    <= 1'b0;
            vr           <= 1'b0;
            cam          <= 1'b0;
            tooth_strobe <= 1'b0;
            rev_strobe   <= 1'b0;
        end else begin
            tick         <= tick_nxt;
            tooth_idx    <= idx_nxt;
            per          <= per_nxt;
            target       <= target_nxt;
            cam_phase    <= phase_nxt;
            vr           <= vr_nxt;
            cam          <= cam_nxt;
            tooth_strobe <= ts_nxt;
            rev_strobe   <= rs_nxt;
        end
    end

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Testbench for trigger_wheel_gen: directed scenarios followed by random
// stimulus, every cycle checked against a position-based reference model.
module tb_trigger_wheel_gen;

    localparam int unsigned TEETH      = 60;
    localparam int unsigned GAP        = 2;
    localparam int unsigned PW         = 16;
    localparam int unsigned PERIOD_RST = 8;
    localparam int unsigned CAM_ON     = 4;
    localparam int unsigned CAM_OFF    = 54;
    localparam int unsigned IW         = $clog2(TEETH);

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [PW-1:0] period;
    logic          period_ld;
    logic [PW-1:0] ramp_step;
    logic          vr;
    logic          cam;
    logic [IW-1:0] tooth_idx;
    logic          tooth_strobe;
    logic          rev_strobe;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within slot, slot number, revolution count
    int m_pos, m_slot, m_rev, m_per, m_tgt;
    bit m_ts, m_rs;

    // Directed-step scratch
    int c, rises, first_rise, first_fall, camhi, len, k, strobes;
    bit prev_vr;
    int exp_len [5];

    always #5 clk = ~clk;

    trigger_wheel_gen #(
        .TEETH(TEETH), .GAP(GAP), .PW(PW), .PERIOD_RST(PERIOD_RST),
        .CAM_ON(CAM_ON), .CAM_OFF(CAM_OFF)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .period(period),
        .period_ld(period_ld), .ramp_step(ramp_step), .vr(vr), .cam(cam),
        .tooth_idx(tooth_idx), .tooth_strobe(tooth_strobe),
        .rev_strobe(rev_strobe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge
    task automatic model_step();
        int nt;
        if (rst) begin
            m_pos = 0; m_slot = 0; m_rev = 0;
            m_per = PERIOD_RST; m_tgt = PERIOD_RST;
            m_ts = 0; m_rs = 0;
            return;
        end
        nt = period_ld ? ((int'(period) < 2) ? 2 : int'(period)) : m_tgt;
        m_tgt = nt;
        m_ts = 0;
        m_rs = 0;
        if (ena) begin
            if (m_pos == m_per - 1) begin
                m_pos = 0;
                m_ts  = 1;
                if (m_slot == TEETH - 1) begin
                    m_slot = 0; m_rev++; m_rs = 1;
                end else begin
                    m_slot++;
                end
`ifdef TRIGGER_WHEEL_GEN_RAMP_EN
                begin
                    int st;
                    int dist;
                    st   = int'(ramp_step);
                    dist = (nt > m_per) ? nt - m_per : m_per - nt;
                    if (st == 0 || dist <= st) m_per = nt;
                    else if (nt > m_per)       m_per = m_per + st;
                    else                       m_per = m_per - st;
                end
`else
                m_per = nt;
`endif
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: update model at the edge, compare all outputs mid-cycle
    task automatic cyc();
        bit e_vr, e_cam;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e_vr  = (m_slot < int'(TEETH - GAP)) && (m_pos >= m_per / 2);
        e_cam = (m_rev % 2 == 1) && (m_slot >= int'(CAM_ON)) && (m_slot < int'(CAM_OFF));
        chk("tooth_idx", 32'(tooth_idx), 32'(m_slot));
        chk("vr", 32'(vr), 32'(e_vr));
        chk("cam", 32'(cam), 32'(e_cam));
        chk("tooth_strobe", 32'(tooth_strobe), 32'(m_ts));
        chk("rev_strobe", 32'(rev_strobe), 32'(m_rs));
    endtask

    // Run until the next tooth_strobe, returning the cycles taken
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tooth_strobe && n < 400);
        chk("wait_strobe", 32'(tooth_strobe), 32'd1);
    endtask

    task automatic load(input int p);
        period    = PW'(p);
        period_ld = 1'b1;
        cyc();
        period_ld = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset
        rst = 1'b1; ena = 1'b0; period_ld = 1'b0;
        period = PW'(8); ramp_step = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // First revolution from reset: tooth shape, gap, no cam
        ena = 1'b1;
        c = 0; rises = 0; first_rise = 0; first_fall = 0; camhi = 0; prev_vr = 0;
        do begin
            cyc(); c++;
            if (vr && !prev_vr) begin rises++; if (first_rise == 0) first_rise = c; end
            if (!vr && prev_vr && first_fall == 0) first_fall = c;
            prev_vr = vr;
            if (cam) camhi++;
        end while (!rev_strobe && c < 1000);
        chk("rev0_len", 32'(c), 32'(TEETH * PERIOD_RST));
        chk("rev0_pulses", 32'(rises), 32'(TEETH - GAP));
        chk("slot0_rise", 32'(first_rise), 32'd4);
        chk("slot0_fall", 32'(first_fall), 32'd8);
        chk("rev0_cam_cycles", 32'(camhi), 32'd0);

        // Second revolution: cam high from slot CAM_ON to CAM_OFF
        c = 0; camhi = 0; rises = 0; prev_vr = 0;
        do begin
            cyc(); c++;
            if (vr && !prev_vr) rises++;
            prev_vr = vr;
            if (cam) camhi++;
        end while (!rev_strobe && c < 1000);
        chk("rev1_len", 32'(c), 32'(TEETH * PERIOD_RST));
        chk("rev1_pulses", 32'(rises), 32'(TEETH - GAP));
        chk("rev1_cam_cycles", 32'(camhi), 32'((CAM_OFF - CAM_ON) * PERIOD_RST));

        // Period load at tick 3: current slot keeps 8, next slot 20
        cyc(); cyc(); cyc();
        load(20);
        wait_strobe(len);
        chk("slot_at_load", 32'(4 + len), 32'd8);
        k = 0;
        do begin cyc(); k++; end while (!vr && k < 100);
        chk("slot20_rise", 32'(k), 32'd10);
        wait_strobe(len);
        chk("slot20_len", 32'(k + len), 32'd20);
        load(8);
        wait_strobe(len);

        // Ramp 8 -> 16 with ramp_step 2
        ramp_step = PW'(2);
        load(16);
        wait_strobe(len);
`ifdef TRIGGER_WHEEL_GEN_RAMP_EN
        exp_len = '{10, 12, 14, 16, 16};
`else
        exp_len = '{16, 16, 16, 16, 16};
`endif
        for (int i = 0; i < 5; i++) begin
            wait_strobe(len);
            chk("ramp_slot_len", 32'(len), 32'(exp_len[i]));
        end
        ramp_step = '0;
        load(8);
        wait_strobe(len);

        // Pause mid-slot for 50 cycles, loading a new period while paused
        cyc(); cyc(); cyc();
        ena = 1'b0;
        strobes = 0;
        for (int i = 0; i < 50; i++) begin
            period    = PW'(12);
            period_ld = (i == 10);
            cyc();
            if (tooth_strobe || rev_strobe) strobes++;
        end
        period_ld = 1'b0;
        chk("pause_strobes", 32'(strobes), 32'd0);
        ena = 1'b1;
        wait_strobe(len);
        chk("resume_remaining", 32'(len), 32'd5);
        wait_strobe(len);
        chk("paused_load_len", 32'(len), 32'd12);
        load(8);
        wait_strobe(len);

        // Reset at slot 30 while vr is high, with a non-default period active
        load(12);
        k = 0;
        while (!(m_slot == 30 && m_pos >= m_per / 2) && k < 1000) begin
            cyc(); k++;
        end
        chk("reach_slot30_vr", 32'(vr), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_vr", 32'(vr), 32'd0);
        chk("rst_idx", 32'(tooth_idx), 32'd0);
        wait_strobe(len);
        chk("post_rst_slot", 32'(len), 32'(PERIOD_RST));
        wait_strobe(len);
        chk("post_rst_slot2", 32'(len), 32'(PERIOD_RST));
        c = 0; camhi = 0;
        do begin
            cyc(); c++;
            if (cam) camhi++;
        end while (!rev_strobe && c < 1000);
        chk("post_rst_cam_cycles", 32'(camhi), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 9) != 0);
            period_ld = ($urandom_range(0, 19) == 0);
            period    = PW'($urandom_range(0, 12));
            ramp_step = PW'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0;
        period_ld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
